// File: rtl/sequence_det2_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The KMP-style functions build the FSM transition table from the pattern.
package sequence_det_pkg;

  localparam logic [3:0] SEQ_DEFAULT = 4'b0101;

  // Bits needed to hold the values 0..n.
  function automatic int state_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << w) < (n + 1)) w = i + 1;
    end
    return w;
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input logic [15:0] p, input int n, input int i);
    logic [15:0] s;
    s = p >> (n - 1 - i);
    return s[0];
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of its first k bits.
  function automatic int kmp_fail(input logic [15:0] p, input int n, input int k);
    int res;
    logic ok;
    res = 0;
    for (int j = 1; j < k; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (pat_bit(p, n, i) != pat_bit(p, n, k - j + i)) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  // Next match length from match length k after receiving bit b.
  // A full match first falls back to fail(n) or to zero, depending on overlap.
  function automatic int next_match(input logic [15:0] p, input int n,
                                    input bit overlap, input int k, input int b);
    int base;
    int res;
    logic ok;
    logic sbit;
    if (k >= n) base = overlap ? kmp_fail(p, n, n) : 0;
    else        base = k;
    res = 0;
    for (int j = 1; j <= base + 1; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        sbit = ((base + 1 - j + i) < base) ? pat_bit(p, n, base + 1 - j + i) : b[0];
        if (pat_bit(p, n, i) != sbit) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

endpackage

// File: rtl/sequence_det2_if.sv
// Serial stream connection: one data bit in, one registered detect flag out.
interface sequence_det2_if;
  logic x;
  logic z;

  modport master (output x, input z);
  modport slave  (input x, output z);
endinterface

// File: rtl/sequence_det2.sv
// Moore FSM detecting a programmable serial bit pattern; the state is the
// current match length and the transition table is fixed at elaboration.
module sequence_det2
  import sequence_det_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = SEQ_DEFAULT,
  parameter bit           OVERLAP = 1'b1
) (
  input logic            clk,
  input logic            reset,
  sequence_det2_if.slave bus
);

  localparam int SW    = state_width(N);
  localparam int DEPTH = 1 << SW;

  logic [SW-1:0] state;
  logic [SW-1:0] state_next;
  logic [SW-1:0] next_tbl [DEPTH][2];

  // Unreachable encodings above N fall back to the empty match.
  for (genvar k = 0; k < DEPTH; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int NS = (k <= N) ? next_match(16'(PATTERN), N, OVERLAP, k, b) : 0;
      assign next_tbl[k][b] = SW'(NS);
    end
  end

  always_comb begin
    state_next = '0;
    state_next = next_tbl[state][bus.x];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= '0;
    else       state <= state_next;
  end

  assign bus.z = (state == SW'(N));

endmodule

// File: tb/tb_sequence_det2.sv
// Bench for sequence_det2: three parameterisations checked every cycle against
// a bit-history model, plus directed vectors with literal expectations.
module tb_sequence_det2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic x_a   = 1'b0;
  logic x_b   = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sequence_det2_if if0 ();
  sequence_det2_if if1 ();
  sequence_det2_if if2 ();

  assign if0.x = x_a;
  assign if1.x = x_a;
  assign if2.x = x_b;

  sequence_det2 #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  sequence_det2 #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  sequence_det2 #(.N(3), .PATTERN(3'b111),  .OVERLAP(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Model: keep the raw received bits and count since reset (or since the last
  // match when not overlapping); a match is the last n bits equal to the pattern.
  logic [15:0] h0 = '0, h1 = '0, h2 = '0;
  int          c0 = 0, c1 = 0, c2 = 0;
  logic        e0 = 1'b0, e1 = 1'b0, e2 = 1'b0;

  function automatic logic hit(input logic [15:0] h, input int c, input int n, input logic [15:0] p);
    logic [15:0] m;
    m = 16'((32'd1 << n) - 1);
    return (c >= n) && (((h ^ p) & m) == 16'd0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      c0 <= 0;  c1 <= 0;  c2 <= 0;
      e0 <= 1'b0; e1 <= 1'b0; e2 <= 1'b0;
    end else begin
      h0 <= {h0[14:0], x_a};
      c0 <= c0 + 1;
      e0 <= hit({h0[14:0], x_a}, c0 + 1, 4, 16'h0005);
      h1 <= {h1[14:0], x_a};
      c1 <= hit({h1[14:0], x_a}, c1 + 1, 4, 16'h0005) ? 0 : c1 + 1;
      e1 <= hit({h1[14:0], x_a}, c1 + 1, 4, 16'h0005);
      h2 <= {h2[14:0], x_b};
      c2 <= c2 + 1;
      e2 <= hit({h2[14:0], x_b}, c2 + 1, 3, 16'h0007);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_ovl", 8'(if0.z), 8'(e0));
    checkOutput("model_novl", 8'(if1.z), 8'(e1));
    checkOutput("model_111", 8'(if2.z), 8'(e2));
  end

  task automatic applyStimulus(input logic a, input logic b);
    @(negedge clk);
    x_a = a;
    x_b = b;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_pulse_z0", 8'(if0.z), 8'd0);
    checkOutput("rst_pulse_z1", 8'(if1.z), 8'd0);
    checkOutput("rst_pulse_state", 8'(dut0.state), 8'd0);
    #1 reset = 1'b0;
  endtask

  bit s_ovl [16] = '{0,0,1,0,1,0,1,0,0,0,1,0,1,0,1,1};
  bit z_ovl [16] = '{0,0,0,0,1,0,1,0,0,0,0,0,1,0,1,0};
  bit z_nov [16] = '{0,0,0,0,1,0,0,0,0,0,0,0,1,0,0,0};
  bit s_fail [8] = '{0,1,1,0,0,1,0,1};

  initial begin
    $display("[TB] reset phase");
    reset = 1'b1;
    #3 x_a = 1'b1;
    #1 checkOutput("rst_z_a", 8'(if0.z), 8'd0);
    #4 x_a = 1'b0;
    #1 checkOutput("rst_z_b", 8'(if1.z), 8'd0);
    #4 x_a = 1'b1;
    #1 checkOutput("rst_z_c", 8'(if2.z), 8'd0);
    #3 reset = 1'b0;
    checkOutput("rst_state0", 8'(dut0.state), 8'd0);
    checkOutput("rst_state1", 8'(dut1.state), 8'd0);
    checkOutput("rst_state2", 8'(dut2.state), 8'd0);

    $display("[TB] overlap / non-overlap stream");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(s_ovl[i], 1'b0);
      checkOutput($sformatf("ovl_s%0d", i + 1), 8'(if0.z), 8'(z_ovl[i]));
      checkOutput($sformatf("novl_s%0d", i + 1), 8'(if1.z), 8'(z_nov[i]));
    end

    $display("[TB] mid-match reset");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mid_pre", 8'(if0.z), 8'd0);
    pulse_reset();
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_after1_ovl", 8'(if0.z), 8'd0);
    checkOutput("mid_after1_novl", 8'(if1.z), 8'd0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mid_before_last", 8'(if0.z), 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_match_ovl", 8'(if0.z), 8'd1);
    checkOutput("mid_match_novl", 8'(if1.z), 8'd1);

    $display("[TB] failure-path stream");
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s_fail[i], 1'b0);
      checkOutput($sformatf("fail_s%0d", i + 1), 8'(if0.z), (i == 7) ? 8'd1 : 8'd0);
      checkOutput($sformatf("fail_novl_s%0d", i + 1), 8'(if1.z), (i == 7) ? 8'd1 : 8'd0);
    end

    $display("[TB] all-ones pattern, N=3");
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("ones_s%0d", i + 1), 8'(if2.z), (i >= 2) ? 8'd1 : 8'd0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("ones_drop", 8'(if2.z), 8'd0);

    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
